mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_BITS, default 2, setting the address width of both requester ports and of the memory-controller address bus.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read, for requester 0 / 1.
REQ-006 addr0, addr1  input  ADDR_BITS each  target address for requester 0 / 1.
REQ-007 wdata0, wdata1  input  8 each  write data for requester 0 / 1.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-009 rdata0, rdata1  output  8 each  registered read data, valid while the matching ack is high and held until that requester's next read completes.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 mc_addr  output  ADDR_BITS  address to the memory controller.
REQ-012 mc_data  output  8  write data to the memory controller.
REQ-013 mc_inst  output  4  memory-controller opcode: 0x0 idle, 0x1 write, 0x2 read; no other values are ever driven.
REQ-014 mc_data_out  input  8  registered read data from the memory controller, valid one cycle after a read opcode is issued.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE and DONE.
REQ-016 In IDLE, the block SHALL grant on the clock edge when any eligible request is high, latch the owner's we/addr/wdata, and move to ISSUE.
REQ-017 A requester whose ack is high in the current cycle SHALL NOT be eligible in that cycle, so a request held through its ack does not re-grant.
REQ-018 With one eligible request, that requester SHALL be granted.
REQ-019 With both eligible, the requester not granted most recently SHALL be granted (round-robin), and the last-grant pointer SHALL update on every grant.
REQ-020 In ISSUE, mc_inst SHALL be 0x1 if the latched we = 1, else 0x2, with mc_addr/mc_data from the latched values; the next state SHALL be DONE.
REQ-021 In DONE, mc_inst SHALL be 0x0.
REQ-022 On the DONE→IDLE edge, the owner's ack SHALL be set for exactly one cycle.
REQ-023 For a read, rdata of the owner SHALL load mc_data_out on the DONE→IDLE edge; for a write, rdata SHALL be unchanged.
REQ-024 Latency SHALL be: request sampled in IDLE at cycle N, ISSUE at N+1, DONE at N+2, ack high in N+3; back-to-back service SHALL allow a new grant in the ack cycle.
REQ-025 Request inputs changing in ISSUE or DONE SHALL NOT affect the operation in flight; only the latched copy SHALL be used.
REQ-026 In IDLE and DONE, mc_addr and mc_data SHALL hold the last latched values; mc_inst SHALL be 0x0.
REQ-027 Address wrap SHALL NOT be handled: addresses pass through unmodified at ADDR_BITS width.

Reset
REQ-028 While reset = 0, mc_inst SHALL be forced to 0x0 combinationally, so an ISSUE interrupted by reset commits no write.
REQ-029 On a clock edge with reset = 0, the block SHALL reset: state to IDLE, ack0/ack1 to 0, rdata0/rdata1 to 0x00, mc_addr to 0, mc_data to 0x00, and the last-grant pointer to requester 1 (requester 0 wins the first tie).
REQ-030 A transaction aborted by reset SHALL produce no ack after reset is released.
REQ-031 busy SHALL be 0 in the first cycle after reset is released.

Verification
REQ-032 Single write, then read, from requester 0:
- write: req0=1, we0=1, addr0=2, wdata0=0xA5 → mc_inst=0x1 at N+1, ack0 at N+3.
- read: req0=1, we0=0, addr0=2 → ack0 with rdata0=0xA5.
REQ-033 Tie after reset:
- stimulus: req0=req1=1, both reads, held through their acks.
- response: requester 0 is served first and requester 1 second; ack0 at N+3, ack1 at N+6; no double ack to either.
REQ-034 Continuous contention for 4 transactions → grants alternate 0,1,0,1, and busy stays high except in each ack cycle.
REQ-035 Reset mid-write:
- stimulus: reset=0 asserted during ISSUE of a write of 0x3C to addr 1.
- response: mc_inst=0x0, the memory is not written, and no ack follows.
- check: a subsequent read of addr 1 returns the prior value.
REQ-036 Single request changed mid-flight: addr0 changed from 0 to 3 during ISSUE → the access still uses addr 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory controller.
// Each grant runs IDLE -> ISSUE -> DONE and returns a one-cycle ack to its owner.
module mem_arbiter #(
  parameter int unsigned ADDR_BITS = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [7:0]           wdata0,
  input  logic [7:0]           wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [7:0]           rdata0,
  output logic [7:0]           rdata1,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] mc_addr,
  output logic [7:0]           mc_data,
  output logic [3:0]           mc_inst,
  input  logic [7:0]           mc_data_out
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned INST_W = 4;
  localparam logic [INST_W-1:0] INST_IDLE  = INST_W'(0);
  localparam logic [INST_W-1:0] INST_WRITE = INST_W'(1);
  localparam logic [INST_W-1:0] INST_READ  = INST_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q;       // 1 = requester 1 owns the transaction in flight
  logic   last_grant_q;  // 1 = requester 1 was granted most recently
  logic   we_q;
  logic   elig0_c, elig1_c, pick1_c, grant_c;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, grant selection and opcode; opcode is gated by reset so an
  // interrupted ISSUE never reaches the controller.
  always_comb begin
    state_d = state_q;
    grant_c = 1'b0;
    mc_inst = INST_IDLE;
    elig0_c = req0 & ~ack0;
    elig1_c = req1 & ~ack1;
    pick1_c = elig1_c & (~elig0_c | ~last_grant_q);
    case (state_q)
      IDLE: begin
        if (elig0_c | elig1_c) begin
          grant_c = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = DONE;
        if (reset) begin
          mc_inst = we_q ? INST_WRITE : INST_READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, ack pulse and read-data capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      mc_addr      <= '0;
      mc_data      <= DATA_W'(0);
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= DATA_W'(0);
      rdata1       <= DATA_W'(0);
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant_c) begin
        owner_q      <= pick1_c;
        last_grant_q <= pick1_c;
        we_q         <= pick1_c ? we1 : we0;
        mc_addr      <= pick1_c ? addr1 : addr0;
        mc_data      <= pick1_c ? wdata1 : wdata0;
      end
      if (state_q == DONE) begin
        if (owner_q) begin
          ack1 <= 1'b1;
          if (!we_q) rdata1 <= mc_data_out;
        end else begin
          ack0 <= 1'b1;
          if (!we_q) rdata0 <= mc_data_out;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small memory-controller model.
module tb_mem_arbiter;

  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [7:0]    wdata0 = 8'h00, wdata1 = 8'h00;
  logic          ack0, ack1, busy;
  logic [7:0]    rdata0, rdata1, mc_data;
  logic [AW-1:0] mc_addr;
  logic [3:0]    mc_inst;
  logic [7:0]    mc_data_out = 8'h00;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_BITS(AW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mc_addr(mc_addr), .mc_data(mc_data), .mc_inst(mc_inst),
    .mc_data_out(mc_data_out)
  );

  // Memory controller: write on 0x1, registered read data on 0x2
  logic [7:0] mem [4];
  initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;
  always @(posedge clock) begin
    if (mc_inst == 4'h1) mem[mc_addr] <= mc_data;
    else if (mc_inst == 4'h2) mc_data_out <= mem[mc_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit chk_busy = 1'b0;
  int rd_model [2] = '{0, 0};

  typedef struct { int who; int rd; int at; } exp_t;
  exp_t sbq [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected ack: owner, read data it must present, and the cycle it must appear
  task automatic push_exp(input int who, input bit we, input int rd, input int delay);
    exp_t e;
    if (!we) rd_model[who] = rd;
    e.who = who;
    e.rd  = rd_model[who];
    e.at  = cyc + delay;
    sbq.push_back(e);
  endtask

  task automatic drive(input int who, input bit we, input int addr, input int wd);
    if (who == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr[AW-1:0]; wdata0 = wd[7:0];
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr[AW-1:0]; wdata1 = wd[7:0];
    end
  endtask

  task automatic wait_ack(input int who);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clock); #1;
      seen = (who == 0) ? ack0 : ack1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ack, expected one", who);
    end
  endtask

  // Full isolated transaction: request, wait for ack, drop, one idle cycle
  task automatic txn(input int who, input bit we, input int addr, input int wd, input int rd);
    drive(who, we, addr, wd);
    push_exp(who, we, rd, 3);
    wait_ack(who);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    @(posedge clock); #1;
  endtask

  // Monitor: every ack is popped against the scoreboard
  always @(negedge clock) begin
    exp_t e;
    int   who;
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      who = (ack1 === 1'b1) ? 1 : 0;
      if (ack0 === 1'b1 && ack1 === 1'b1) chk("dual_ack", 1, 0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: requester %0d acked at cycle %0d, expected no ack", who, cyc);
      end else begin
        e = sbq.pop_front();
        chk("ack_owner", who, e.who);
        chk("ack_cycle", cyc, e.at);
        chk("ack_rdata", int'(who == 1 ? rdata1 : rdata0), e.rd);
      end
    end
    if (chk_busy) chk("busy_contention", int'(busy), int'(!(ack0 || ack1)));
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mc_addr", mc_addr, 0);
    chk("rst_mc_data", mc_data, 0);
    chk("rst_mc_inst", mc_inst, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("busy_after_reset", busy, 0);
    @(posedge clock); #1;

    // Write 0xA5 to addr 2 from requester 0, with opcode timing
    drive(0, 1'b1, 2, 8'hA5);
    push_exp(0, 1'b1, 0, 3);
    @(posedge clock); #1;
    @(negedge clock);
    chk("issue_inst_wr", mc_inst, 1);
    chk("issue_addr", mc_addr, 2);
    chk("issue_data", mc_data, 8'hA5);
    chk("issue_busy", busy, 1);
    @(negedge clock);
    chk("done_inst", mc_inst, 0);
    chk("done_addr_hold", mc_addr, 2);
    wait_ack(0);
    req0 = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("idle_data_hold", mc_data, 8'hA5);
    @(posedge clock); #1;

    // Read it back
    txn(0, 1'b0, 2, 0, 8'hA5);

    // Requester 1 fills addr 3 and addr 1; its rdata must stay 0 on writes
    txn(1, 1'b1, 3, 8'h5A, 0);
    txn(1, 1'b1, 1, 8'h11, 0);

    // Continuous contention: 0,1,0,1
    drive(0, 1'b0, 2, 0);
    drive(1, 1'b0, 3, 0);
    push_exp(0, 1'b0, 8'hA5, 3);
    push_exp(1, 1'b0, 8'h5A, 6);
    push_exp(0, 1'b0, 8'hA5, 9);
    push_exp(1, 1'b0, 8'h5A, 12);
    @(posedge clock); #1;
    chk_busy = 1'b1;
    wait_ack(0);
    wait_ack(1);
    wait_ack(0);
    req0 = 1'b0;
    wait_ack(1);
    req1 = 1'b0;
    chk_busy = 1'b0;
    @(posedge clock); #1;

    // Reset during ISSUE of a write of 0x3C to addr 1
    drive(0, 1'b1, 1, 8'h3C);
    @(posedge clock); #1;
    reset = 1'b0;
    req0  = 1'b0;
    @(negedge clock);
    chk("rst_issue_inst", mc_inst, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    rd_model[0] = 0;
    rd_model[1] = 0;
    @(negedge clock);
    chk("busy_after_abort", busy, 0);
    repeat (6) @(posedge clock);
    #1;

    // Tie right after reset: requester 0 first, both held through their acks
    drive(0, 1'b0, 1, 0);
    drive(1, 1'b0, 3, 0);
    push_exp(0, 1'b0, 8'h11, 3);
    push_exp(1, 1'b0, 8'h5A, 6);
    wait_ack(0);
    @(posedge clock); #1;
    req0 = 1'b0;
    wait_ack(1);
    @(posedge clock); #1;
    req1 = 1'b0;
    repeat (4) @(posedge clock);
    #1;

    // Address changed mid-flight must not affect the access
    txn(1, 1'b1, 0, 8'h77, 0);
    drive(0, 1'b0, 0, 0);
    push_exp(0, 1'b0, 8'h77, 3);
    @(posedge clock); #1;
    addr0 = 2'd3;
    @(negedge clock);
    chk("midflight_addr", mc_addr, 0);
    chk("midflight_inst_rd", mc_inst, 2);
    wait_ack(0);
    req0 = 1'b0;

    repeat (6) @(posedge clock);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
